// File: rtl/t08_wb_sram_responder.sv
// Wishbone slave backed by a word-addressed SRAM with byte-lane writes.
// Fixed-latency ack (WAIT_STATES extra cycles), out-of-range flagging, and abort on cyc drop.
module t08_wb_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        oor_o
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic        ack_q, ack_d;
    logic        oor_q, oor_d;
    logic [31:0] rdat_q, rdat_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic          commit;
    logic          mem_we;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [31:0]   t_adr;
    logic          t_we;
    logic [3:0]    t_sel;
    logic [31:0]   t_dat;

    assign req = wbs_cyc_i && wbs_stb_i;

    // With zero wait states the commit happens on the sampling edge itself,
    // so the transaction fields come straight from the bus instead of the latches.
    always_comb begin
        if (state_q == S_IDLE) begin
            t_adr = wbs_adr_i;
            t_we  = wbs_we_i;
            t_sel = wbs_sel_i;
            t_dat = wbs_dat_i;
        end else begin
            t_adr = adr_q;
            t_we  = we_q;
            t_sel = sel_q;
            t_dat = dat_q;
        end
    end

    assign in_range = ({1'b0, t_adr} >= {1'b0, BASE_ADDR}) && ({1'b0, t_adr} < LIMIT);
    assign idx      = AW'((t_adr - BASE_ADDR) >> 2);
    assign commit   = (state_q == S_IDLE && req && WAIT_STATES == 0) ||
                      (state_q == S_WAIT && wbs_cyc_i && cnt_q == 4'd0);
    assign mem_we   = commit && t_we && in_range && nRst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        oor_d   = 1'b0;
        rdat_d  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    adr_d = wbs_adr_i;
                    we_d  = wbs_we_i;
                    sel_d = wbs_sel_i;
                    dat_d = wbs_dat_i;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_M1;
                    end
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            ack_d = 1'b1;
            oor_d = !in_range;
            if (!t_we) begin
                rdat_d = in_range ? mem[idx] : 32'hBADD_BADD;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            oor_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            oor_q   <= oor_d;
            rdat_q  <= rdat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (t_sel[b]) begin
                    mem[idx][8*b +: 8] <= t_dat[8*b +: 8];
                end
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign oor_o     = oor_q;
    assign wbs_dat_o = rdat_q;

endmodule

// File: tb/tb_t08_wb_sram_responder.sv
// Directed and randomized checks of the Wishbone SRAM responder against a word-array model.
// Instance 0 uses default parameters, instance 1 uses zero wait states.
module tb_t08_wb_sram_responder;

    localparam logic [31:0] BASE  = 32'h3300_0000;
    localparam int          DEPTH = 256;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, dat = '0;
    bit          dsel = 1'b0;

    logic        ack0, ack1, oor0, oor1;
    logic [31:0] dat0, dat1;
    logic        ack, oor;
    logic [31:0] dat_o;

    int checks = 0;
    int failures = 0;
    int idle_nz = 0;

    logic [31:0] m [2][DEPTH];

    t08_wb_sram_responder u_dut0 (
        .clk(clk), .nRst(nRst),
        .wbs_cyc_i(cyc && !dsel), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack0), .wbs_dat_o(dat0), .oor_o(oor0)
    );

    t08_wb_sram_responder #(.WAIT_STATES(0)) u_dut1 (
        .clk(clk), .nRst(nRst),
        .wbs_cyc_i(cyc && dsel), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack1), .wbs_dat_o(dat1), .oor_o(oor1)
    );

    assign ack   = dsel ? ack1 : ack0;
    assign oor   = dsel ? oor1 : oor0;
    assign dat_o = dsel ? dat1 : dat0;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(4 * DEPTH));
    endfunction

    // One bus transaction; lat counts edges from the sampling edge to the edge that sees ack.
    // mode 0 = normal, 1 = scramble inputs and drop stb in WAIT, 2 = drop cyc in WAIT.
    task automatic bus(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] dt,
                       input int mode, output int lat, output logic [31:0] rd, output logic o);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = dt;
        @(posedge clk);
        lat = -1; rd = '0; o = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ack) begin
                lat = n; rd = dat_o; o = oor;
                break;
            end
            if (dat_o !== 32'h0) idle_nz++;
            if (n == 1 && mode == 1) begin
                stb = 1'b0; adr = $urandom; dat = $urandom; we = ~w; sel = 4'($urandom);
            end
            if (n == 1 && mode == 2) begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic txn(input string tag, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] dt, input int mode);
        int          lat, exp_lat, d;
        logic [31:0] rd, ex;
        logic        o, ir;
        logic [7:0]  wi;
        d  = dsel ? 1 : 0;
        ir = in_rng(a);
        wi = 8'((a - BASE) >> 2);
        ex = ir ? m[d][wi] : 32'hBADD_BADD;
        exp_lat = (mode == 2) ? -1 : (d == 1 ? 1 : 3);
        bus(w, s, a, dt, mode, lat, rd, o);
        chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        if (mode != 2) begin
            chk({tag, "/oor"}, 32'(o), 32'(!ir));
            if (!w) chk({tag, "/rdata"}, rd, ex);
            if (w && ir) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) m[d][wi][8*b +: 8] = dt[8*b +: 8];
            end
        end
    endtask

    initial begin
        int          n, acks;
        logic [31:0] a, rd;
        int unsigned r;

        // Reset values, held with the clock running
        repeat (2) @(posedge clk);
        #1;
        chk("rst/ack0", 32'(ack0), 32'h0);
        chk("rst/oor0", 32'(oor0), 32'h0);
        chk("rst/dat0", dat0, 32'h0);
        chk("rst/ack1", 32'(ack1), 32'h0);
        chk("rst/dat1", dat1, 32'h0);
        @(negedge clk);
        nRst = 1'b1;

        // Known contents for words that a wrapped index would hit
        txn("pre_w0",   1'b1, 4'hF, BASE,          32'h0000_AAAA, 0);
        txn("pre_w255", 1'b1, 4'hF, BASE + 32'h3FC, 32'hFFFF_5555, 0);
        txn("pre_w5",   1'b1, 4'hF, BASE + 32'h14,  32'h5555_0005, 0);

        txn("basic_wr", 1'b1, 4'hF, 32'h3300_0010, 32'hDEAD_BEEF, 0);
        txn("basic_rd", 1'b0, 4'h0, 32'h3300_0010, 32'h0, 0);

        txn("lane_wr1", 1'b1, 4'hF,    32'h3300_0020, 32'h1122_3344, 0);
        txn("lane_wr2", 1'b1, 4'b0101, 32'h3300_0020, 32'hAABB_CCDD, 0);
        txn("lane_rd",  1'b0, 4'hF,    32'h3300_0020, 32'h0, 0);
        chk("lane_model", m[0][8], 32'h11BB_33DD);

        txn("sel0_wr", 1'b1, 4'h0, 32'h3300_0010, 32'h0123_4567, 0);
        txn("sel0_rd", 1'b0, 4'h0, 32'h3300_0013, 32'h0, 0);

        txn("oor_rd_end", 1'b0, 4'hF, 32'h3300_0400, 32'h0, 0);
        txn("oor_wr_low", 1'b1, 4'hF, 32'h32FF_FFFC, 32'h7777_7777, 0);
        txn("oor_wr_end", 1'b1, 4'hF, 32'h3300_0400, 32'h8888_8888, 0);
        txn("oor_chk0",   1'b0, 4'hF, BASE,           32'h0, 0);
        txn("oor_chk255", 1'b0, 4'hF, BASE + 32'h3FC, 32'h0, 0);
        txn("oor_rd_top", 1'b0, 4'hF, 32'hFFFF_FFFC,  32'h0, 0);

        // Latched values govern: scrambled inputs and stb drop during WAIT
        txn("latch_wr", 1'b1, 4'b1100, BASE + 32'h30, 32'hC0DE_0000, 1);
        txn("latch_rd", 1'b0, 4'hF,    BASE + 32'h30, 32'h0, 0);

        // Abort by dropping cyc one cycle into WAIT
        txn("abort_wr", 1'b1, 4'hF, BASE + 32'h14, 32'h0BAD_F00D, 2);
        txn("abort_rd", 1'b0, 4'hF, BASE + 32'h14, 32'h0, 0);

        // Back-to-back: read word 8 then write it, cyc/stb never dropped
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h20;
        @(posedge clk);
        n = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ack) begin n = i; rd = dat_o; break; end
        end
        chk("b2b/lat1", 32'(n), 32'd3);
        chk("b2b/rd1", rd, 32'h11BB_33DD);
        we = 1'b1; dat = 32'hCAFE_F00D;
        @(negedge clk);
        chk("b2b/gap", 32'(ack), 32'h0);
        n = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ack) begin n = i; break; end
        end
        chk("b2b/lat2", 32'(n), 32'd3);
        cyc = 1'b0; stb = 1'b0;
        m[0][8] = 32'hCAFE_F00D;
        @(negedge clk);
        chk("b2b/one_cycle", 32'(ack), 32'h0);
        txn("b2b_rd", 1'b0, 4'hF, BASE + 32'h20, 32'h0, 0);

        // Reset between edges during WAIT of a write
        txn("rst_pre", 1'b1, 4'hF, BASE + 32'h18, 32'h6666_6666, 0);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h18; dat = 32'h0BAD_0BAD;
        @(posedge clk);
        @(negedge clk);
        #1 nRst = 1'b0;
        #1;
        chk("rst_wait/ack", 32'(ack0), 32'h0);
        chk("rst_wait/dat", dat0, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack0) acks++;
        end
        chk("rst_wait/no_ack", 32'(acks), 32'h0);
        txn("rst_wait_rd", 1'b0, 4'hF, BASE + 32'h18, 32'h0, 0);

        // Reset while a read ack is on the bus clears outputs immediately
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3300_0010;
        @(posedge clk);
        n = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ack0) begin n = i; break; end
        end
        chk("rst_ack/seen", 32'(n), 32'd3);
        chk("rst_ack/data", dat0, 32'hDEAD_BEEF);
        #1 nRst = 1'b0;
        #1;
        chk("rst_ack/ack", 32'(ack0), 32'h0);
        chk("rst_ack/dat", dat0, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack0) acks++;
        end
        chk("rst_ack/no_ack", 32'(acks), 32'h0);

        // Zero-wait-state instance: fill, then random traffic against the model
        dsel = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            txn("fill", 1'b1, 4'hF, BASE + 32'(4 * i), $urandom, 0);
        for (int t = 0; t < 1000; t++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       a = BASE - 32'(4 * $urandom_range(1, 16)) + 32'($urandom_range(0, 3));
                1:       a = BASE + 32'h400 + 32'($urandom_range(0, 63));
                2:       a = $urandom;
                default: a = BASE + 32'($urandom_range(0, 1023));
            endcase
            txn("rand", 1'($urandom), 4'($urandom), a, $urandom, 0);
        end
        dsel = 1'b0;

        chk("dat_o_zero_without_ack", 32'(idle_nz), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t08_wb_sram_responder.md
T08_WB_SRAM_RESPONDER -- requirements
Module: t08_wb_sram_responder

Interface
REQ-001: The block SHALL have parameter BASE_ADDR, default 32'h3300_0000, meaning the byte address of memory word 0.
REQ-002: The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words, a power of two from 16 to 1024.
REQ-003: The block SHALL have parameter WAIT_STATES, default 2, meaning the extra stall cycles before ack, range 0-15.
REQ-004: The block SHALL have port clk, input, width 1, meaning the single clock; all logic is rising-edge.
REQ-005: The block SHALL have port nRst, input, width 1, meaning the asynchronous active-low reset.
REQ-006: The block SHALL have ports wbs_cyc_i and wbs_stb_i, input, width 1 each, meaning Wishbone bus cycle and strobe.
REQ-007: The block SHALL have port wbs_we_i, input, width 1, meaning 1 = write, 0 = read.
REQ-008: The block SHALL have port wbs_sel_i, input, width 4, meaning byte-lane enables, where bit n covers data bits [8n+7:8n].
REQ-009: The block SHALL have ports wbs_adr_i and wbs_dat_i, input, width 32 each, meaning byte address and write data.
REQ-010: The block SHALL have port wbs_ack_o, output, width 1, meaning the one-cycle transfer acknowledge.
REQ-011: The block SHALL have port wbs_dat_o, output, width 32, meaning read data, valid while wbs_ack_o=1.
REQ-012: The block SHALL have port oor_o, output, width 1, meaning a one-cycle pulse coincident with an ack for an out-of-range access.

Function
REQ-013: The block SHALL implement an FSM with states IDLE, WAIT and ACK.
REQ-014: In IDLE, the block SHALL detect a request as wbs_cyc_i=1 and wbs_stb_i=1 at a rising edge.
- On a request, it SHALL latch adr, we, sel and dat.
- It SHALL go to WAIT if WAIT_STATES>0, otherwise to ACK.
REQ-015: WAIT SHALL load a counter with WAIT_STATES-1 on entry, decrement it each cycle, and go to ACK on the edge where the counter equals 0.
REQ-016: wbs_ack_o SHALL be registered and be 1 only in ACK.
- ACK therefore lasts exactly one cycle.
- Ack rises on edge k+1+WAIT_STATES, where k is the edge at which the request was sampled.
REQ-017: ACK SHALL always return to IDLE.
- If cyc and stb are still high in the following IDLE cycle, that is a new back-to-back transaction, sampled normally.
REQ-018: The address SHALL be in range iff BASE_ADDR <= adr < BASE_ADDR + 4*DEPTH_WORDS.
- The word index is (adr - BASE_ADDR) >> 2.
- adr[1:0] SHALL be ignored.
- The range computation SHALL be 33 bits wide so that BASE_ADDR near 32'hFFFF_FFFF cannot wrap.
REQ-019: An in-range write SHALL update only the lanes with sel=1, on the edge entering ACK; sel=4'b0000 SHALL change no bytes but SHALL still ack.
REQ-020: For an in-range read, wbs_dat_o SHALL hold the full 32-bit word, regardless of sel, during ACK.
REQ-021: An out-of-range access SHALL still ack with the normal latency.
- A write SHALL change no memory.
- A read SHALL return 32'hBADD_BADD.
- oor_o SHALL be 1 during that ACK cycle.
REQ-022: wbs_dat_o SHALL be 32'h0 in every cycle where wbs_ack_o=0.
REQ-023: Abort: if wbs_cyc_i=0 is sampled while in WAIT, the FSM SHALL return to IDLE with no write and no ack; wbs_stb_i=0 alone SHALL NOT abort.
REQ-024: Request inputs SHALL be ignored while the FSM is in WAIT or ACK; the latched values govern the transaction.

Reset
REQ-025: While nRst=0 the FSM SHALL be IDLE, the counter 0, and wbs_ack_o, oor_o and wbs_dat_o all 0, immediately and without waiting for clk.
REQ-026: Reset during WAIT or ACK SHALL abandon the transaction.
- A write not yet committed SHALL be lost.
- No ack SHALL appear after reset releases.
REQ-027: Memory contents SHALL NOT be cleared by reset and are undefined until written.

Verification
REQ-028: Default parameters; write 32'hDEAD_BEEF to 32'h3300_0010 with sel=4'hF, then read the same address -> each ack occurs exactly 3 edges after sampling, and the read returns 32'hDEAD_BEEF.
REQ-029: Write 32'h1122_3344 with sel=4'hF, then write 32'hAABB_CCDD with sel=4'b0101, then read -> 32'h11BB_33DD.
REQ-030: Read 32'h3300_0400 (first address past the end) -> ack with 32'hBADD_BADD and oor_o=1; a write to 32'h32FF_FFFC leaves all memory unchanged.
REQ-031: Drop wbs_cyc_i one cycle into WAIT of a write to word 5 -> no ack, and word 5 keeps its previous value; hold cyc and stb high across two transactions -> two separate one-cycle acks.
REQ-032: Assert nRst=0 between edges during WAIT of a write -> ack and dat_o drop at once, no ack follows, and the target word is unchanged.
REQ-033: WAIT_STATES=0 -> ack appears on the edge after sampling; run 1000 random transactions against a reference-model memory with zero mismatches.
